// File: rtl/aes_stream_framer.sv
// aes_stream_framer: serialises an AES job (command, key block(s), optional IV, data blocks)
// into 32-bit stream words. Define AES_FRAMER_STATS_EN to add stat_jobs/stat_words counters.
module aes_stream_framer #(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int BLK_CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [31:0]               job_cmd,
   input  logic                      job_key256,
   input  logic                      job_need_iv,
   input  logic [255:0]              job_key,
   input  logic [127:0]              job_iv,
   input  logic [BLK_CNT_WIDTH-1:0]  job_nblk,
   input  logic                      blk_valid,
   output logic                      blk_ready,
   input  logic [127:0]              blk_data,
   output logic                      out_tvalid,
   input  logic                      out_tready,
   output logic [BUS_DATA_WIDTH-1:0] out_tdata,
   output logic                      out_tlast,
   output logic                      job_done,
   output logic                      job_err
`ifdef AES_FRAMER_STATS_EN
   ,
   output logic [31:0]               stat_jobs,
   output logic [31:0]               stat_words
`endif
);

   if (BUS_DATA_WIDTH != 32) begin : g_bad_width
      $error("aes_stream_framer: only BUS_DATA_WIDTH=32 is supported");
   end

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_KEY_LO, S_KEY_HI, S_IV, S_DATA} state_t;

   localparam logic [BLK_CNT_WIDTH-1:0] BLK_ONE = {{(BLK_CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                      state_q, state_d, nxt_hdr;
   logic [1:0]                  wcnt_q, wcnt_d;
   logic [BLK_CNT_WIDTH-1:0]    bcnt_q, bcnt_d;
   logic [BLK_CNT_WIDTH-1:0]    nblk_q, nblk_d;
   logic [31:0]                 cmd_q, cmd_d;
   logic                        key256_q, key256_d;
   logic                        need_iv_q, need_iv_d;
   logic [255:0]                key_q, key_d;
   logic [127:0]                iv_q, iv_d;
   logic [127:0]                shreg_q, shreg_d;
   logic                        tvalid_q, tvalid_d;
   logic [BUS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
   logic                        tlast_q, tlast_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
   logic                        hs, last_blk, load_blk;
   logic [127:0]                cur_item, nxt_item;

   function automatic logic [31:0] word_of(input logic [127:0] it, input logic [1:0] w);
      case (w)
         2'd0:    word_of = it[127:96];
         2'd1:    word_of = it[95:64];
         2'd2:    word_of = it[63:32];
         default: word_of = it[31:0];
      endcase
   endfunction

   function automatic logic [127:0] item_of(input state_t s, input logic [31:0] c,
                                            input logic [255:0] k, input logic [127:0] v);
      case (s)
         S_CMD:    item_of = {96'b0, c};
         S_KEY_LO: item_of = k[127:0];
         S_KEY_HI: item_of = k[255:128];
         S_IV:     item_of = v;
         default:  item_of = '0;
      endcase
   endfunction

   assign job_ready  = (state_q == S_IDLE);
   assign out_tvalid = tvalid_q;
   assign out_tdata  = tdata_q;
   assign out_tlast  = tlast_q;
   assign job_done   = done_q;
   assign job_err    = err_q;

   assign hs       = tvalid_q && out_tready;
   assign last_blk = (bcnt_q == nblk_q - BLK_ONE);
   assign cur_item = item_of(state_q, cmd_q, key_q, iv_q);
   assign nxt_item = item_of(nxt_hdr, cmd_q, key_q, iv_q);

   always_comb begin
      nxt_hdr = S_DATA;
      case (state_q)
         S_CMD:    nxt_hdr = S_KEY_LO;
         S_KEY_LO: nxt_hdr = key256_q ? S_KEY_HI : (need_iv_q ? S_IV : S_DATA);
         S_KEY_HI: nxt_hdr = need_iv_q ? S_IV : S_DATA;
         default:  nxt_hdr = S_DATA;
      endcase
   end

   // state_q/wcnt_q name the word held in the output register (or, in DATA with
   // tvalid low, the block word 0 still waiting for blk_valid).
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      bcnt_d    = bcnt_q;
      nblk_d    = nblk_q;
      cmd_d     = cmd_q;
      key256_d  = key256_q;
      need_iv_d = need_iv_q;
      key_d     = key_q;
      iv_d      = iv_q;
      shreg_d   = shreg_q;
      tvalid_d  = tvalid_q;
      tdata_d   = tdata_q;
      tlast_d   = tlast_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      load_blk  = 1'b0;
      blk_ready = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (job_valid) begin
               cmd_d     = job_cmd;
               key256_d  = job_key256;
               need_iv_d = job_need_iv;
               key_d     = job_key;
               iv_d      = job_iv;
               nblk_d    = job_nblk;
               if (job_nblk == '0) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = S_CMD;
                  wcnt_d   = 2'd0;
                  tvalid_d = 1'b1;
                  tdata_d  = word_of({96'b0, job_cmd}, 2'd0);
                  tlast_d  = 1'b0;
               end
            end
         end
         default: begin
            if (hs) begin
               if (wcnt_q != 2'd3) begin
                  wcnt_d = wcnt_q + 2'd1;
                  if (state_q == S_DATA) begin
                     tdata_d = shreg_q[127:96];
                     shreg_d = {shreg_q[95:0], 32'b0};
                     tlast_d = (wcnt_q == 2'd2) && last_blk;
                  end else begin
                     tdata_d = word_of(cur_item, wcnt_q + 2'd1);
                     tlast_d = 1'b0;
                  end
               end else if (state_q == S_DATA && last_blk) begin
                  state_d  = S_IDLE;
                  wcnt_d   = 2'd0;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  state_d = nxt_hdr;
                  wcnt_d  = 2'd0;
                  tlast_d = 1'b0;
                  if (nxt_hdr == S_DATA) begin
                     bcnt_d   = (state_q == S_DATA) ? bcnt_q + BLK_ONE : '0;
                     tvalid_d = 1'b0;
                     load_blk = 1'b1;
                  end else begin
                     tvalid_d = 1'b1;
                     tdata_d  = word_of(nxt_item, 2'd0);
                  end
               end
            end else if (state_q == S_DATA && !tvalid_q) begin
               load_blk = 1'b1;
            end

            // Taking the block straight into the output register avoids a bubble
            // between the last word of one item and the first data word.
            if (load_blk) begin
               blk_ready = blk_valid;
               if (blk_valid) begin
                  tvalid_d = 1'b1;
                  tdata_d  = blk_data[127:96];
                  shreg_d  = {blk_data[95:0], 32'b0};
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         bcnt_q    <= '0;
         nblk_q    <= '0;
         cmd_q     <= '0;
         key256_q  <= 1'b0;
         need_iv_q <= 1'b0;
         key_q     <= '0;
         iv_q      <= '0;
         shreg_q   <= '0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tlast_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         bcnt_q    <= bcnt_d;
         nblk_q    <= nblk_d;
         cmd_q     <= cmd_d;
         key256_q  <= key256_d;
         need_iv_q <= need_iv_d;
         key_q     <= key_d;
         iv_q      <= iv_d;
         shreg_q   <= shreg_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tlast_q   <= tlast_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef AES_FRAMER_STATS_EN
   logic [31:0] stat_jobs_q, stat_words_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_jobs_q  <= '0;
         stat_words_q <= '0;
      end else begin
         if (done_q) stat_jobs_q <= stat_jobs_q + 32'd1;
         if (hs)     stat_words_q <= stat_words_q + 32'd1;
      end
   end

   assign stat_jobs  = stat_jobs_q;
   assign stat_words = stat_words_q;
`endif

endmodule

// File: tb/tb_aes_stream_framer.sv
// Randomised bench for aes_stream_framer: expected stream built from the job description
// as a queue of 128-bit items split into words, compared on every handshake.
module tb_aes_stream_framer;
   logic         clk = 1'b0;
   logic         resetn;
   logic         job_valid, job_ready, job_key256, job_need_iv;
   logic [31:0]  job_cmd;
   logic [255:0] job_key;
   logic [127:0] job_iv;
   logic [15:0]  job_nblk;
   logic         blk_valid, blk_ready;
   logic [127:0] blk_data;
   logic         out_tvalid, out_tready, out_tlast, job_done, job_err;
   logic [31:0]  out_tdata;
`ifdef AES_FRAMER_STATS_EN
   logic [31:0]  stat_jobs, stat_words;
`endif

   int checks = 0, errors = 0, cyc = 0;

   aes_stream_framer dut (
      .clk(clk), .resetn(resetn),
      .job_valid(job_valid), .job_ready(job_ready), .job_cmd(job_cmd),
      .job_key256(job_key256), .job_need_iv(job_need_iv), .job_key(job_key),
      .job_iv(job_iv), .job_nblk(job_nblk),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
      .out_tlast(out_tlast), .job_done(job_done), .job_err(job_err)
`ifdef AES_FRAMER_STATS_EN
      , .stat_jobs(stat_jobs), .stat_words(stat_words)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] rnd256();
      return {rnd128(), rnd128()};
   endfunction

   // trm: 0 tready=1, 1 toggling, 2 random. gap: hold blk_valid low 5 cycles after D0.
   // abort_at >= 0: assert reset while word index abort_at is presented.
   task automatic run_job(input logic [31:0] cmd, input logic k256, input logic niv,
                          input logic [255:0] key, input logic [127:0] iv, input int nblk,
                          input int trm, input bit gap, input int abort_at);
      logic [127:0] items[$];
      logic [127:0] blks[$];
      logic [31:0]  exp_q[$];
      logic [127:0] it;
      logic [31:0]  exp_w, prev_data;
      logic         stall_prev = 1'b0;
      int hs = 0, done_cnt = 0, err_cnt = 0, brdy_cnt = 0, bubbles = 0;
      int post = 0, since = 0, last_hs_c = -10, total;
      bit fin = 1'b0;

      if (nblk > 0) begin
         items.push_back({96'b0, cmd});
         items.push_back(key[127:0]);
         if (k256) items.push_back(key[255:128]);
         if (niv) items.push_back(iv);
         for (int b = 0; b < nblk; b++) begin
            it = rnd128();
            blks.push_back(it);
            items.push_back(it);
         end
      end
      foreach (items[i]) begin
         it = items[i];
         for (int w = 0; w < 4; w++) exp_q.push_back(it[127-32*w -: 32]);
      end
      total = exp_q.size();

      @(negedge clk);
      blk_valid   = 1'b0;
      out_tready  = 1'b1;
      job_valid   = 1'b1;
      job_cmd     = cmd;
      job_key256  = k256;
      job_need_iv = niv;
      job_key     = key;
      job_iv      = iv;
      job_nblk    = 16'(nblk);
      #1 chk("job_ready_idle", job_ready, 1);
      @(negedge clk);
      job_valid   = 1'b0;
      job_cmd     = $urandom;
      job_key256  = 1'($urandom);
      job_need_iv = 1'($urandom);
      job_key     = rnd256();
      job_iv      = rnd128();
      job_nblk    = 16'($urandom);

      for (int c = 0; c < 3000 && !fin; c++) begin
         if (brdy_cnt > 0) since++;
         case (trm)
            0:       out_tready = 1'b1;
            1:       out_tready = cyc[0];
            default: out_tready = ($urandom_range(0, 3) != 0);
         endcase
         blk_valid = (blks.size() > 0) && !(gap && brdy_cnt == 1 && since >= 1 && since <= 5);
         blk_data  = (blks.size() > 0) ? blks[0] : rnd128();
         job_valid = (trm == 2) && (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
         #1;
         if (c == 0) begin
            chk("first_valid", out_tvalid, nblk > 0);
            if (nblk == 0) begin
               chk("err_pulse", job_err, 1);
               chk("ready_after_err", job_ready, 1);
            end
         end
         if (abort_at >= 0 && hs == abort_at) begin
            resetn = 1'b0;
            #1;
            chk("rst_tvalid", out_tvalid, 0);
            chk("rst_ready", job_ready, 1);
            chk("rst_tlast", out_tlast, 0);
            chk("rst_tdata", out_tdata, 0);
            chk("rst_blk_ready", blk_ready, 0);
            job_valid = 1'b0;
            blk_valid = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            return;
         end
         if (job_done) begin
            done_cnt++;
            chk("done_timing", last_hs_c, c - 1);
         end
         if (job_err) err_cnt++;
         if (exp_q.size() > 0 && hs > 0 && !out_tvalid) bubbles++;
         if (exp_q.size() > 0) chk("ready_busy", job_ready, 0);
         if (stall_prev) begin
            chk("hold_valid", out_tvalid, 1);
            chk("hold_data", out_tdata, prev_data);
         end
         if (blk_valid && blk_ready) begin
            void'(blks.pop_front());
            brdy_cnt++;
            since = 0;
         end
         if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
               chk("extra_word", hs + 1, total);
            end else begin
               exp_w = exp_q.pop_front();
               chk("word", out_tdata, exp_w);
               chk("tlast", out_tlast, exp_q.size() == 0);
               if (exp_q.size() == 0) last_hs_c = c;
            end
            hs++;
         end
         stall_prev = out_tvalid && !out_tready;
         prev_data  = out_tdata;
         if ((nblk == 0 && c >= 2) || done_cnt > 0) post++;
         if (post >= 2) fin = 1'b1;
         @(negedge clk);
      end
      job_valid = 1'b0;
      blk_valid = 1'b0;
      chk("timeout", fin, 1);
      chk("nwords", hs, total);
      chk("done_cnt", done_cnt, nblk > 0);
      chk("err_cnt", err_cnt, nblk == 0);
      chk("blk_ready_cnt", brdy_cnt, nblk);
      if (!gap || trm == 0) chk("bubbles", bubbles, (gap && nblk >= 2) ? 2 : 0);
   endtask

   initial begin
      resetn      = 1'b1;
      job_valid   = 1'b0;
      job_cmd     = '0;
      job_key256  = 1'b0;
      job_need_iv = 1'b0;
      job_key     = '0;
      job_iv      = '0;
      job_nblk    = '0;
      blk_valid   = 1'b0;
      blk_data    = '0;
      out_tready  = 1'b1;
      #2 resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tvalid0", out_tvalid, 0);
      chk("rst_tdata0", out_tdata, 0);
      chk("rst_tlast0", out_tlast, 0);
      chk("rst_done0", job_done, 0);
      chk("rst_err0", job_err, 0);
      chk("rst_blk_ready0", blk_ready, 0);
      chk("rst_job_ready0", job_ready, 1);
      resetn = 1'b1;

      run_job(32'h0000_0011, 1'b0, 1'b0, rnd256(), rnd128(), 1, 0, 1'b0, -1);
      run_job(32'h0000_0125, 1'b1, 1'b1, rnd256(), rnd128(), 2, 1, 1'b0, -1);
`ifdef AES_FRAMER_STATS_EN
      chk("stat_jobs", stat_jobs, 2);
      chk("stat_words", stat_words, 36);
`endif
      run_job(32'h0000_0021, 1'b0, 1'b1, rnd256(), rnd128(), 2, 0, 1'b1, -1);
      run_job(32'h0000_0011, 1'b0, 1'b0, rnd256(), rnd128(), 0, 0, 1'b0, -1);
      run_job(32'h0000_0011, 1'b0, 1'b0, rnd256(), rnd128(), 1, 0, 1'b0, 6);
      run_job(32'h0000_0011, 1'b0, 1'b0, rnd256(), rnd128(), 1, 0, 1'b0, -1);
      for (int j = 0; j < 8; j++)
         run_job($urandom, 1'($urandom), 1'($urandom), rnd256(), rnd128(),
                 int'($urandom_range(1, 4)), 2, 1'($urandom), -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_stream_framer.md
Name: aes_stream_framer

Overview:
- Host-side transmitter that builds the 32-bit input stream the AES controller consumes.
- Per job, emits in order: command block, key block(s), optional IV block, then N data blocks.
- Each 128-bit item goes out as 4 bus words; tlast is set on the final word of the final data block.
- Sits between a job/descriptor source (DMA engine or test sequencer) and the controller input bus.

Parameters:
- BUS_DATA_WIDTH, 32, output word width; only 32 is supported (elaboration error otherwise).
- BLK_CNT_WIDTH, 16, width of the per-job data block count.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  framer idle, accepts descriptor
- job_cmd  in  32  command word; mode/key-size/direction flags in controller encoding
- job_key256  in  1  1: send two key blocks; 0: send one
- job_need_iv  in  1  1: send IV block after the key(s)
- job_key  in  256  key; [127:0] is the first key block, [255:128] the second
- job_iv  in  128  IV
- job_nblk  in  BLK_CNT_WIDTH  number of data blocks
- blk_valid  in  1  data block available
- blk_ready  out  1  data block consumed
- blk_data  in  128  data block
- out_tvalid  out  1  stream word valid
- out_tready  in  1  downstream ready
- out_tdata  out  32  stream word
- out_tlast  out  1  last word of job
- job_done  out  1  one-cycle pulse when the final word handshakes
- job_err  out  1  one-cycle pulse when a job with nblk==0 is dropped

Behaviour:
- Reset values (asynchronous): state IDLE; out_tvalid=0, out_tdata=0, out_tlast=0, job_done=0, job_err=0, blk_ready=0, all latched descriptor fields = 0.
- job_ready = (state==IDLE). Descriptor is captured on job_valid && job_ready.
- States: IDLE, CMD, KEY_LO, KEY_HI, IV, DATA.
  - IDLE -> CMD.
  - CMD -> KEY_LO.
  - KEY_LO -> KEY_HI if key256, else IV if need_iv, else DATA.
  - KEY_HI -> IV if need_iv, else DATA.
  - IV -> DATA.
  - DATA -> IDLE after the last word of block nblk.
- Each state emits one 128-bit item as 4 words through a 2-bit word counter, most significant word first: [127:96], [95:64], [63:32], [31:0].
- The state advances when word 3 handshakes.
- CMD item = {96'b0, job_cmd}, so the command occupies [31:0] of the block.
- Output register: out_tdata, out_tvalid and out_tlast are registered.
  - Once out_tvalid=1, tdata and tlast are held stable until out_tvalid && out_tready.
  - Next word may present in the cycle after a handshake: back-to-back, 1 word/cycle at full throughput.
- First word (CMD word 0) is valid 1 cycle after descriptor capture.
- DATA state:
  - blk_ready pulses for exactly one cycle when entering a new block and blk_valid=1.
  - The block is captured into a 128-bit shift register; no word is emitted until a block is captured.
  - Stalls on blk_valid=0 hold out_tvalid=0; no bubbles are inserted otherwise.
- out_tlast=1 only on word 3 of data block index nblk-1; 0 on every header word.
- job_done pulses the cycle after the tlast handshake, coincident with the return to IDLE.
- job_nblk==0: descriptor is accepted, no words are emitted, job_err pulses 1 cycle later, state stays IDLE.
- Block counter counts up to nblk-1. nblk = 2^BLK_CNT_WIDTH-1 must work without wrap.
- Descriptor inputs are ignored except during the capture cycle. job_valid while busy is not accepted.
- Reset mid-frame:
  - all outputs return to reset values immediately.
  - the partial frame is abandoned; no tlast is emitted.
  - the downstream must be reset with it.

Optional Feature:
- Macro AES_FRAMER_STATS_EN.
- Defined: adds output ports stat_jobs (32, count of job_done pulses) and stat_words (32, count of out handshakes). Both counters reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ECB-128, cmd=0x00000011, key=K, nblk=1, tready=1:
  - exactly 12 words: 00000000,00000000,00000000,00000011, then K[127:96]..K[31:0], then block words.
  - tlast only on word 12; job_done pulses once.
- CBC-256 with IV, nblk=2, tready toggling 1/0 every cycle:
  - 24 words in order CMD, KEY_LO, KEY_HI, IV, D0, D1.
  - tdata stable while stalled; tlast only on word 24.
- blk_valid low for 5 cycles between D0 and D1:
  - out_tvalid=0 during the gap; no duplicated or lost words; blk_ready pulses exactly twice.
- job_nblk=0:
  - no out_tvalid; job_err pulses 1 cycle after acceptance; job_ready back to 1 the next cycle.
- resetn asserted during KEY_LO word 2:
  - out_tvalid=0 and job_ready=1 after reset.
  - a new ECB job then produces a correct, complete 12-word frame.
- With AES_FRAMER_STATS_EN: after the first two scenarios, stat_jobs=2 and stat_words=36.
